// File: rtl/mult_sched_pkg.sv
// -----------------------------------------------------------------------------
// mult_sched_pkg
// Shared definitions for the repeated-addition multiplier scheduler:
//   - state_t : FSM state encoding (3 bits)
//   - REQ0/REQ1 : owner / grant index constants
//   - WIDTH_DEF : default operand, product and bus width
// -----------------------------------------------------------------------------
package mult_sched_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_ACCUM  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mult_sched_ctrl_if.sv
// -----------------------------------------------------------------------------
// mult_sched_ctrl_if
// Bundles the requester handshake and the datapath control/status bus.
//   slave  : view of the scheduler (mult_sched_ctrl)
//   master : view of the environment (requesters + multiplier datapath)
// Signals:
//   req0/req1, a0/b0/a1/b1 : requests and operand pairs
//   busy, done0/done1, result : status and completion back to requesters
//   Lda/Ldb/Ldp/Clrp/Decb, data_in : datapath control strobes and input bus
//   eqz, product : datapath B==0 flag and P register value
// -----------------------------------------------------------------------------
interface mult_sched_ctrl_if
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             busy;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] result;
  logic             Lda;
  logic             Ldb;
  logic             Ldp;
  logic             Clrp;
  logic             Decb;
  logic [WIDTH-1:0] data_in;
  logic             eqz;
  logic [WIDTH-1:0] product;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, eqz, product,
    output busy, done0, done1, result, Lda, Ldb, Ldp, Clrp, Decb, data_in
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, eqz, product,
    input  busy, done0, done1, result, Lda, Ldb, Ldp, Clrp, Decb, data_in
  );

endinterface

// File: rtl/mult_sched_ctrl_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter, purely combinational.
//   i_req0, i_req1 : requests
//   i_last_grant   : index granted last time (held by the parent)
//   i_en           : arbitration enable (parent is ready to accept)
//   o_valid        : a grant is issued this cycle
//   o_idx          : granted requester index
// -----------------------------------------------------------------------------
module rr_arbiter2
  import mult_sched_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  input  logic i_en,
  output logic o_valid,
  output logic o_idx
);

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = REQ0;
    if (i_en && (i_req0 || i_req1)) begin
      o_valid = 1'b1;
      if (i_req0 && i_req1) begin
        // Tie: the requester that was not served last time wins.
        o_idx = (i_last_grant == REQ0) ? REQ1 : REQ0;
      end else begin
        o_idx = i_req1 ? REQ1 : REQ0;
      end
    end
  end

endmodule

// File: rtl/mult_sched_ctrl.sv
// -----------------------------------------------------------------------------
// mult_sched_ctrl
// Scheduler/sequencer for a shared repeated-addition multiplier datapath.
// Arbitrates two requesters round-robin, captures the winner's operands,
// sequences LOAD_A -> LOAD_B -> ACCUM -> DONE, and returns the product with a
// one-cycle done pulse to the granted requester.
//   clock : single clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : requester handshake + datapath control (slave view)
// -----------------------------------------------------------------------------
module mult_sched_ctrl
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clock,
  input  logic               rst_n,
  mult_sched_ctrl_if.slave   bus
);

  state_t           r_state;
  logic             r_last_grant;
  logic             r_owner;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_data_in;
  logic             r_busy;
  logic             r_done0;
  logic             r_done1;
  logic             r_lda;
  logic             r_ldb;
  logic             r_clrp;
  logic             r_accum;

  logic             w_grant_valid;
  logic             w_grant_idx;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  rr_arbiter2 u_arb (
    .i_req0       (bus.req0),
    .i_req1       (bus.req1),
    .i_last_grant (r_last_grant),
    .i_en         (r_state == ST_IDLE),
    .o_valid      (w_grant_valid),
    .o_idx        (w_grant_idx)
  );

  assign w_sel_a = (w_grant_idx == REQ1) ? bus.a1 : bus.a0;
  assign w_sel_b = (w_grant_idx == REQ1) ? bus.b1 : bus.b0;

  // NOTE: operand registers carry no reset; they are always written at the
  // grant edge before anything reads them.
  always_ff @(posedge clock) begin
    if (r_state == ST_IDLE && w_grant_valid) begin
      r_op_a <= w_sel_a;
      r_op_b <= w_sel_b;
    end
  end

  // Outputs are registered alongside the state: each transition also loads
  // the strobe pattern of the state being entered.
  // NOTE: non-blocking assignments throughout, so every right-hand side sees
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= REQ1;
      r_owner      <= REQ0;
      r_result     <= '0;
      r_data_in    <= '0;
      r_busy       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_lda        <= 1'b0;
      r_ldb        <= 1'b0;
      r_clrp       <= 1'b0;
      r_accum      <= 1'b0;
    end else begin
      r_lda   <= 1'b0;
      r_ldb   <= 1'b0;
      r_clrp  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_owner      <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_busy       <= 1'b1;
            r_lda        <= 1'b1;
            r_data_in    <= w_sel_a;
            r_state      <= ST_LOAD_A;
          end
        end
        ST_LOAD_A: begin
          r_ldb     <= 1'b1;
          r_clrp    <= 1'b1;
          r_data_in <= r_op_b;
          r_state   <= ST_LOAD_B;
        end
        ST_LOAD_B: begin
          r_accum <= 1'b1;
          r_state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (bus.eqz) begin
            r_result  <= bus.product;
            r_accum   <= 1'b0;
            r_data_in <= '0;
            r_done0   <= (r_owner == REQ0);
            r_done1   <= (r_owner == REQ1);
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy    <= 1'b0;
          r_accum   <= 1'b0;
          r_data_in <= '0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Add/decrement follow eqz directly so the last ACCUM cycle issues no add.
  assign bus.Ldp     = r_accum & ~bus.eqz;
  assign bus.Decb    = r_accum & ~bus.eqz;
  assign bus.Lda     = r_lda;
  assign bus.Ldb     = r_ldb;
  assign bus.Clrp    = r_clrp;
  assign bus.data_in = r_data_in;
  assign bus.busy    = r_busy;
  assign bus.done0   = r_done0;
  assign bus.done1   = r_done1;
  assign bus.result  = r_result;

endmodule

// File: tb/tb_mult_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_sched_ctrl
// Self-checking bench for mult_sched_ctrl: a datapath model closes the loop,
// a job-timeline reference model predicts every output each cycle, and
// directed scenarios pin literal results and latencies.
// -----------------------------------------------------------------------------
module tb_mult_sched_ctrl;

  localparam int W = 16;

  logic clock;
  logic rst_n;
  logic chk_en;

  int n_cmp;
  int n_mis;

  mult_sched_ctrl_if #(.WIDTH(W)) bus ();

  mult_sched_ctrl #(.WIDTH(W)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Multiplier datapath: A register, P accumulator with clear, B down-counter.
  // Registers move with the strobes seen at the rising edge, so eqz observed
  // at a rising edge reflects all decrements issued by earlier ACCUM cycles.
  // ---------------------------------------------------------------------------
  logic [W-1:0] dp_a, dp_b, dp_p;
  initial begin
    dp_a = '0;
    dp_b = '0;
    dp_p = '0;
  end
  always @(posedge clock) begin
    if (bus.Lda) dp_a <= bus.data_in;
    if (bus.Ldb) dp_b <= bus.data_in;
    else if (bus.Decb) dp_b <= dp_b - 1'b1;
    if (bus.Clrp) dp_p <= '0;
    else if (bus.Ldp) dp_p <= dp_p + dp_a;
  end
  assign bus.eqz     = (dp_b == '0);
  assign bus.product = dp_p;

  // ---------------------------------------------------------------------------
  // Reference model: a job is a timeline t = edges since the grant edge.
  //   t=0 LOAD_A, t=1 LOAD_B, t=2..b+2 ACCUM (adds while t-2 < b),
  //   t=b+3 DONE (result = a*b mod 2^W), then idle.
  // ---------------------------------------------------------------------------
  logic         m_active;
  logic         m_owner;
  logic         m_last;
  logic [W-1:0] m_a;
  int           m_b;
  int           m_t;
  logic [W-1:0] m_result;

  initial begin
    m_active = 1'b0;
    m_owner  = 1'b0;
    m_last   = 1'b1;
    m_a      = '0;
    m_b      = 0;
    m_t      = 0;
    m_result = '0;
  end

  always @(posedge clock) begin : model
    logic win;
    if (!rst_n) begin
      m_active <= 1'b0;
      m_last   <= 1'b1;
      m_result <= '0;
      m_t      <= 0;
    end else if (m_active) begin
      if (m_t == m_b + 3) begin
        m_active <= 1'b0;
      end else begin
        m_t <= m_t + 1;
        if (m_t + 1 == m_b + 3)
          m_result <= W'((int'(m_a) * m_b) & 32'hFFFF);
      end
    end else if (bus.req0 || bus.req1) begin
      win = (bus.req0 && bus.req1) ? !m_last : bus.req1;
      m_owner  <= win;
      m_last   <= win;
      m_a      <= win ? bus.a1 : bus.a0;
      m_b      <= int'(win ? bus.b1 : bus.b0);
      m_t      <= 0;
      m_active <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle compare of every DUT output against the model.
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin : cmp
    logic       e_accum;
    logic       e_add;
    logic [4:0] e_strb;
    logic [1:0] e_done;
    logic [W-1:0] e_din;
    if (chk_en) begin
      e_accum = m_active && (m_t >= 2) && (m_t <= m_b + 2);
      e_add   = e_accum && (m_t - 2 < m_b);
      e_strb  = {m_active && m_t == 0, m_active && m_t == 1, e_add,
                 m_active && m_t == 1, e_add};
      e_done  = (m_active && m_t == m_b + 3) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      if (!m_active)                 e_din = '0;
      else if (m_t == 0)             e_din = m_a;
      else if (m_t == 1 || e_accum)  e_din = W'(m_b);
      else                           e_din = '0;
      check("busy", 32'(bus.busy), 32'(m_active));
      check("strobes", 32'({bus.Lda, bus.Ldb, bus.Ldp, bus.Clrp, bus.Decb}), 32'(e_strb));
      check("done", 32'({bus.done1, bus.done0}), 32'(e_done));
      check("done_excl", 32'(bus.done0 & bus.done1), 32'd0);
      check("result", 32'(bus.result), 32'(m_result));
      check("data_in", 32'(bus.data_in), 32'(e_din));
    end
  end

  // Waits for the next done pulse; n counts falling edges after the req was
  // driven (the first one follows the grant edge), so DONE shows at n = b+4.
  task automatic wait_done(input string name, input int n0, input int exp_n,
                           input logic exp_owner, input logic [W-1:0] exp_res);
    int  n;
    bit  seen;
    n    = n0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clock);
      n++;
      if (bus.done0 || bus.done1) begin
        seen = 1'b1;
        check({name, "_owner"}, 32'(bus.done1), 32'(exp_owner));
        check({name, "_result"}, 32'(bus.result), 32'(exp_res));
        if (exp_n > 0) check({name, "_latency"}, n, exp_n);
      end
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_done"}, 32'({bus.done1, bus.done0}), 32'd0);
    check({name, "_result"}, 32'(bus.result), 32'd0);
    check({name, "_strobes"}, 32'({bus.Lda, bus.Ldb, bus.Ldp, bus.Clrp, bus.Decb}), 32'd0);
    check({name, "_data_in"}, 32'(bus.data_in), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clock);
    chk_en = 1'b1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp    = 0;
    n_mis    = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0   = '0;
    bus.b0   = '0;
    bus.a1   = '0;
    bus.b1   = '0;
    @(negedge clock);
    do_reset();

    // Single job 7*5, operands disturbed after the grant and mid-ACCUM.
    bus.req0 = 1'b1; bus.a0 = 16'd7; bus.b0 = 16'd5;
    @(negedge clock);
    bus.req0 = 1'b0; bus.a0 = 16'd100; bus.b0 = 16'd100;
    repeat (3) @(negedge clock);
    bus.a0 = 16'd11; bus.b0 = 16'd9;
    wait_done("job7x5", 4, 9, 1'b0, 16'd35);

    // Tie from reset: 0 first, then 1, then 0 again while both keep asking.
    @(negedge clock);
    do_reset();
    bus.req0 = 1'b1; bus.a0 = 16'd3; bus.b0 = 16'd4;
    bus.req1 = 1'b1; bus.a1 = 16'd6; bus.b1 = 16'd2;
    wait_done("tie_r0", 0, 8, 1'b0, 16'd12);
    wait_done("tie_r1", -1, 6, 1'b1, 16'd12);
    wait_done("tie_r0_again", -1, 8, 1'b0, 16'd12);
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    // b=0: one ACCUM cycle with no add, result 0.
    @(negedge clock);
    @(negedge clock);
    bus.req1 = 1'b1; bus.a1 = 16'd9; bus.b1 = 16'd0;
    @(negedge clock);
    bus.req1 = 1'b0;
    wait_done("b_zero", 1, 4, 1'b1, 16'd0);

    // Product wraps modulo 2^16.
    @(negedge clock);
    bus.req0 = 1'b1; bus.a0 = 16'hFFFF; bus.b0 = 16'd3;
    @(negedge clock);
    bus.req0 = 1'b0;
    wait_done("wrap", 1, 7, 1'b0, 16'hFFFD);

    // Reset during ACCUM abandons the job; a fresh job then works.
    @(negedge clock);
    bus.req0 = 1'b1; bus.a0 = 16'd5; bus.b0 = 16'd6;
    @(negedge clock);
    bus.req0 = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_accum_busy", 32'(bus.busy), 32'd1);
    do_reset();
    repeat (8) begin
      @(negedge clock);
      check("no_done_after_reset", 32'({bus.done1, bus.done0}), 32'd0);
    end
    bus.req0 = 1'b1; bus.a0 = 16'd2; bus.b0 = 16'd2;
    @(negedge clock);
    bus.req0 = 1'b0;
    wait_done("post_reset", 1, 6, 1'b0, 16'd4);

    // Randomized traffic against the model, with occasional resets.
    repeat (600) begin
      @(negedge clock);
      rst_n    = ($urandom_range(0, 199) != 0);
      bus.req0 = ($urandom_range(0, 3) != 0);
      bus.req1 = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       bus.a0 = 16'h0000;
        1:       bus.a0 = 16'hFFFF;
        default: bus.a0 = W'($urandom);
      endcase
      bus.a1 = W'($urandom);
      bus.b0 = W'($urandom_range(0, 9));
      bus.b1 = W'($urandom_range(0, 9));
    end
    @(negedge clock);
    rst_n    = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (20) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
